// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sequences reads from a 1-cycle-latency BRAM and delivers them as a
// valid/ready stream, using a 3-entry skid FIFO with issue credits so backpressure never drops data.
module bram_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t state, state_nx;
    logic [ADDR_W:0] len_c, issue_cnt, beat_cnt;
    logic [ADDR_W-1:0] addr_cnt, addr_q;
    logic inflight, push, pop, issue;
    logic [DATA_W-1:0] fifo [3];
    logic [1:0] rd_ptr, wr_ptr, count;

    assign len_c = length > DEPTH ? DEPTH : length;
    // Credits count reads still in the RAM pipe, so only occupancy (never m_ready) gates issue.
    assign issue = state == RUN && issue_cnt != '0 && (3'(inflight) + 3'(count)) < 3'd3;
    assign push = inflight;
    assign pop = m_valid && m_ready;
    assign mem_re = issue;
    assign mem_addr = issue ? addr_cnt : addr_q;
    assign m_valid = count != 2'd0;
    assign m_data = m_valid ? fifo[rd_ptr] : '0;
    assign m_last = m_valid && beat_cnt == ONE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = len_c == '0 ? FINISH : RUN;
            RUN: begin
                busy = 1'b1;
                if (pop && beat_cnt == ONE) state_nx = FINISH;
            end
            FINISH: begin
                done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr_cnt <= '0;
            addr_q <= '0;
            issue_cnt <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count <= 2'd0;
        end else begin
            if (state == IDLE && start) begin
                addr_cnt <= base_addr;
                issue_cnt <= len_c;
                beat_cnt <= len_c;
            end
            if (issue) begin
                addr_cnt <= addr_cnt + 1'b1;
                addr_q <= addr_cnt;
                issue_cnt <= issue_cnt - ONE;
            end
            inflight <= issue;
            if (push) wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
                beat_cnt <= beat_cnt - ONE;
            end
            count <= count + 2'(push) - 2'(pop);
        end

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= mem_rdata;
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed jobs against a BRAM model; a scoreboard queues expected
// beats and issue addresses, and a monitor compares them as the DUT presents them.
module tb_bram_stream_reader;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, m_ready = 1'b1;
    logic [9:0] base_addr = '0;
    logic [10:0] length = '0;
    logic busy, done, mem_re, m_valid, m_last;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata, m_data;
    logic [7:0] ram [1024];
    logic [8:0] bq [$];
    logic [9:0] aq [$];
    int errors = 0, checks = 0, beats_seen = 0;
    bit rand_ready = 1'b0;

    bram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 1024; i++) ram[i] = 8'(i);
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: beats, issue addresses, stall stability and FIFO overflow.
    initial begin
        logic stall_q = 1'b0;
        logic [8:0] hold = '0;
        logic [8:0] eb;
        logic [9:0] ea;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (stall_q) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, hold});
                if (m_valid && m_ready) begin
                    if (bq.size() == 0) chk("extra_beat", 1, 0);
                    else begin
                        eb = bq.pop_front();
                        chk("beat", {m_last, m_data}, eb);
                    end
                    beats_seen++;
                end
                if (mem_re) begin
                    if (aq.size() == 0) chk("extra_issue", 1, 0);
                    else begin
                        ea = aq.pop_front();
                        chk("issue_addr", mem_addr, ea);
                    end
                end
                chk("fifo_overflow", dut.push && !dut.pop && dut.count == 2'd3, 0);
                stall_q = m_valid && !m_ready;
                hold = {m_last, m_data};
            end
        end
    end

    task automatic start_job(input logic [9:0] base, input logic [10:0] len);
        int n;
        logic [9:0] a;
        n = len > 11'd1024 ? 1024 : int'(len);
        for (int i = 0; i < n; i++) begin
            a = base + 10'(i);
            bq.push_back({i == n - 1, a[7:0]});
            aq.push_back(a);
        end
        @(posedge clk);
        #1 start = 1'b1; base_addr = base; length = len;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_in_done"}, busy, 0);
        chk({name, "_beats_left"}, bq.size(), 0);
        chk({name, "_issues_left"}, aq.size(), 0);
    endtask

    initial begin
        int b0;
        repeat (2) @(negedge clk);
        chk("reset_vals", {busy, done, mem_re, mem_addr, m_valid, m_data, m_last}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        // Basic job with cycle-exact latency checks
        start_job(10'h010, 11'd4);
        @(negedge clk);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_re", mem_re, 1);
        chk("t1_c1_addr", mem_addr, 10'h010);
        @(negedge clk);
        chk("t1_c2_valid", m_valid, 0);
        @(negedge clk);
        chk("t1_c3_valid", {m_valid, m_data}, {1'b1, 8'h10});
        repeat (4) @(negedge clk);
        chk("t1_c7_done", {done, busy}, 2'b10);
        chk("t1_beats_left", bq.size(), 0);
        // Accepted the cycle after done; address wraps past 0x3FF
        start_job(10'h3FE, 11'd4);
        wait_done(20, "t2");
        // Random backpressure
        rand_ready = 1'b1;
        start_job(10'h123, 11'd16);
        wait_done(400, "t3");
        rand_ready = 1'b0;
        // Empty job
        start_job(10'h055, 11'd0);
        @(negedge clk);
        chk("t4_c1", {done, busy, m_valid}, 3'b100);
        @(negedge clk);
        chk("t4_c2", {done, busy, m_valid}, 3'b000);
        // Full-depth job with an ignored start mid-job
        start_job(10'h2A0, 11'd1024);
        repeat (10) @(posedge clk);
        #1 start = 1'b1; base_addr = 10'h000; length = 11'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(3000, "t5");
        // Clamped length
        start_job(10'h005, 11'd2000);
        wait_done(3000, "t6");
        // Reset mid-job after 5 beats, then a fresh job
        b0 = beats_seen;
        start_job(10'h100, 11'd20);
        for (int k = 0; k < 50 && beats_seen - b0 < 5; k++) @(negedge clk);
        chk("t7_five_beats", beats_seen - b0 >= 5, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("t7_reset_vals", {busy, done, mem_re, mem_addr, m_valid, m_data, m_last}, 0);
        bq.delete();
        aq.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        start_job(10'h200, 11'd3);
        wait_done(50, "t7");
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
